// File: rtl/fpa_add_seq_pkg.sv
// Shared types and helpers for the multi-word add/subtract sequencer.
package fpa_add_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_t;

  // Counter width that stays at least one bit for single-word configurations.
  function automatic int clog2_min1(input int v);
    return (v <= 1) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/multi_word_add_sequencer_cla.sv
// N-bit carry-lookahead adder slice with selectable implementation style,
// plus the per-bit generate/propagate cell used by the structural variant.

module cla_cell (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic g,
  output logic p,
  output logic s
);
  assign g = a & b;
  assign p = a ^ b;
  assign s = p ^ c;
endmodule

module CarryLookAheadAdd #(
  parameter int    N     = 32,
  parameter string MODEL = "Behavioral"
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         ci,
  output logic [N-1:0] s,
  output logic         co
);

  generate
    if (MODEL == "Behavioral") begin : g_beh
      assign {co, s} = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, ci};
    end else if (MODEL == "DataFlow") begin : g_df
      logic [N-1:0] g;
      logic [N-1:0] p;
      logic [N:0]   c;
      assign g    = a & b;
      assign p    = a ^ b;
      assign c[0] = ci;
      for (genvar i = 0; i < N; i++) begin : g_carry
        assign c[i+1] = g[i] | (p[i] & c[i]);
      end
      assign s  = p ^ c[N-1:0];
      assign co = c[N];
    end else begin : g_st
      logic [N-1:0] g;
      logic [N-1:0] p;
      logic [N:0]   c;
      for (genvar i = 0; i < N; i++) begin : g_cell
        cla_cell u_cell (
          .a (a[i]),
          .b (b[i]),
          .c (c[i]),
          .g (g[i]),
          .p (p[i]),
          .s (s[i])
        );
      end
      // Each carry is the flattened lookahead sum of products over all lower bits.
      always_comb begin
        logic t;
        c    = '0;
        c[0] = ci;
        for (int i = 0; i < N; i++) begin
          t = ci;
          for (int j = 0; j <= i; j++) t = g[j] | (p[j] & t);
          c[i+1] = t;
        end
      end
      assign co = c[N];
    end
  endgenerate

endmodule

// File: rtl/multi_word_add_sequencer.sv
// Adds or subtracts N*WORDS-bit operands by running one N-bit CLA slice
// over WORDS cycles, LSW first, with the carry held in a flop between slices.
module multi_word_add_sequencer
  import fpa_add_seq_pkg::*;
#(
  parameter int    N     = 32,
  parameter int    WORDS = 4,
  parameter string MODEL = "Behavioral"
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N*WORDS-1:0] in_a,
  input  logic [N*WORDS-1:0] in_b,
  input  logic             in_ci,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N*WORDS-1:0] out_c,
  output logic             out_co,
  output logic             out_ovf
);

  localparam int W  = N * WORDS;
  localparam int IW = clog2_min1(WORDS);

  seq_state_t    state, state_nxt;
  logic [W-1:0]  a_sh, b_sh, res;
  logic [IW-1:0] idx;
  logic          carry;
  logic          co_r, ovf_r;
  logic [N-1:0]  sum;
  logic          sum_co;
  logic          last;

  CarryLookAheadAdd #(.N(N), .MODEL(MODEL)) u_add (
    .a  (a_sh[N-1:0]),
    .b  (b_sh[N-1:0]),
    .ci (carry),
    .s  (sum),
    .co (sum_co)
  );

  assign last = (idx == IW'(WORDS - 1));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = RUN;
      RUN:     if (last)     state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Subtraction is A + ~B + ~borrow, so B and the carry are inverted at capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh  <= '0;
      b_sh  <= '0;
      res   <= '0;
      idx   <= '0;
      carry <= 1'b0;
      co_r  <= 1'b0;
      ovf_r <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_sh  <= in_a;
          b_sh  <= in_sub ? ~in_b : in_b;
          carry <= in_ci ^ in_sub;
          idx   <= '0;
        end
        RUN: begin
          res   <= W'({sum, res} >> N);
          a_sh  <= a_sh >> N;
          b_sh  <= b_sh >> N;
          carry <= sum_co;
          idx   <= idx + 1'b1;
          if (last) begin
            co_r  <= sum_co;
            ovf_r <= (a_sh[N-1] == b_sh[N-1]) && (sum[N-1] != a_sh[N-1]);
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign out_c     = res;
  assign out_co    = co_r;
  assign out_ovf   = ovf_r;

endmodule

// File: tb/tb_multi_word_add_sequencer.sv
// Runs three sequencer configurations in lockstep against an arithmetic reference.
module tb_multi_word_add_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ci = 1'b0;
  logic        in_sub = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;

  logic [2:0]       rdy, vld, co, ovf;
  logic [2:0][31:0] oc;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  multi_word_add_sequencer #(.N(8), .WORDS(4), .MODEL("Behavioral")) u_beh (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[0]),
    .in_a(in_a), .in_b(in_b), .in_ci(in_ci), .in_sub(in_sub),
    .out_valid(vld[0]), .out_ready(out_ready), .out_c(oc[0]),
    .out_co(co[0]), .out_ovf(ovf[0])
  );

  multi_word_add_sequencer #(.N(8), .WORDS(4), .MODEL("Structural")) u_str (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[1]),
    .in_a(in_a), .in_b(in_b), .in_ci(in_ci), .in_sub(in_sub),
    .out_valid(vld[1]), .out_ready(out_ready), .out_c(oc[1]),
    .out_co(co[1]), .out_ovf(ovf[1])
  );

  multi_word_add_sequencer #(.N(32), .WORDS(1), .MODEL("DataFlow")) u_w1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[2]),
    .in_a(in_a), .in_b(in_b), .in_ci(in_ci), .in_sub(in_sub),
    .out_valid(vld[2]), .out_ready(out_ready), .out_c(oc[2]),
    .out_co(co[2]), .out_ovf(ovf[2])
  );

  function automatic int lat_of(input int d);
    return (d == 2) ? 1 : 4;
  endfunction

  // Reference: plain 32-bit two's-complement arithmetic.
  task automatic model(input logic [31:0] a, input logic [31:0] b, input logic ci,
                       input logic sub, output logic [31:0] c, output logic co_e,
                       output logic ovf_e);
    logic [32:0] t;
    if (!sub) begin
      t     = {1'b0, a} + {1'b0, b} + 33'(ci);
      c     = t[31:0];
      co_e  = t[32];
      ovf_e = (a[31] == b[31]) && (c[31] != a[31]);
    end else begin
      c     = a - b - 32'(ci);
      co_e  = ({1'b0, a} >= ({1'b0, b} + 33'(ci)));
      ovf_e = (a[31] != b[31]) && (c[31] != a[31]);
    end
  endtask

  task automatic op(input logic [31:0] a, input logic [31:0] b, input logic ci,
                    input logic sub, input int hold, input string tag);
    logic [31:0] ec;
    logic        eco, eov;
    int          lat[3];
    int          cyc;
    model(a, b, ci, sub, ec, eco, eov);
    @(negedge clk);
    in_valid = 1'b1; in_a = a; in_b = b; in_ci = ci; in_sub = sub;
    checks++;
    if (rdy !== 3'b111) begin
      failures++; $display("FAIL %s in_ready_before_accept got=%b exp=111", tag, rdy);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_a = $urandom; in_b = $urandom;
    in_ci = 1'($urandom); in_sub = 1'($urandom);
    lat = '{-1, -1, -1};
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
      for (int d = 0; d < 3; d++) if (vld[d] === 1'b1 && lat[d] < 0) lat[d] = cyc;
    end while (vld !== 3'b111 && cyc < 20);
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (lat[d] != lat_of(d)) begin
        failures++; $display("FAIL %s latency dut=%0d got=%0d exp=%0d", tag, d, lat[d], lat_of(d));
      end
      checks++;
      if ({oc[d], co[d], ovf[d]} !== {ec, eco, eov}) begin
        failures++;
        $display("FAIL %s result dut=%0d got c=%h co=%b ovf=%b exp c=%h co=%b ovf=%b",
                 tag, d, oc[d], co[d], ovf[d], ec, eco, eov);
      end
    end
    checks++;
    if (rdy !== 3'b000) begin
      failures++; $display("FAIL %s in_ready_in_done got=%b exp=000", tag, rdy);
    end
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      in_valid = 1'($urandom); in_a = $urandom; in_b = $urandom;
      in_ci = 1'($urandom); in_sub = 1'($urandom);
      @(posedge clk); #1;
      for (int d = 0; d < 3; d++) begin
        checks++;
        if (vld[d] !== 1'b1 || rdy[d] !== 1'b0 || {oc[d], co[d], ovf[d]} !== {ec, eco, eov}) begin
          failures++;
          $display("FAIL %s hold cyc=%0d dut=%0d got vld=%b rdy=%b c=%h exp vld=1 rdy=0 c=%h",
                   tag, h, d, vld[d], rdy[d], oc[d], ec);
        end
      end
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (vld !== 3'b000 || rdy !== 3'b111) begin
      failures++; $display("FAIL %s release got vld=%b rdy=%b exp vld=000 rdy=111", tag, vld, rdy);
    end
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (oc[d] !== ec) begin
        failures++; $display("FAIL %s held_in_idle dut=%0d got=%h exp=%h", tag, d, oc[d], ec);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (rdy !== 3'b111 || vld !== 3'b000 || co !== 3'b000 || ovf !== 3'b000 || oc !== '0) begin
      failures++;
      $display("FAIL reset_state got rdy=%b vld=%b co=%b ovf=%b c0=%h exp rdy=111 vld=000 co=000 ovf=000 c=0",
               rdy, vld, co, ovf, oc[0]);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    op(32'h000000FF, 32'h00000001, 1'b0, 1'b0, 0, "add_ff_1");
    op(32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 0, "add_ripple");
    op(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 0, "add_ovf");
    op(32'h80000000, 32'h00000001, 1'b0, 1'b1, 0, "sub_ovf");
    op(32'h00000005, 32'h00000007, 1'b0, 1'b1, 0, "sub_neg");
    op(32'h00000007, 32'h00000005, 1'b1, 1'b1, 0, "sub_borrow_in");
  endtask

  task automatic test_hold_back_to_back();
    op($urandom, $urandom, 1'b0, 1'b0, 10, "hold");
    op($urandom, $urandom, 1'b1, 1'b1, 0, "back_to_back");
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    in_valid = 1'b1; in_a = $urandom | 32'h1; in_b = $urandom; in_ci = 1'b0; in_sub = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (rdy !== 3'b111 || vld !== 3'b000 || co !== 3'b000 || ovf !== 3'b000 || oc !== '0) begin
      failures++;
      $display("FAIL reset_mid got rdy=%b vld=%b co=%b ovf=%b c0=%h c2=%h exp reset values",
               rdy, vld, co, ovf, oc[0], oc[2]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    op(32'd3, 32'd4, 1'b0, 1'b0, 0, "after_reset");
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++)
      op($urandom, $urandom, 1'($urandom), 1'($urandom), 0, "random");
    op(32'h80000000, 32'h80000000, 1'b0, 1'b0, 0, "add_neg_ovf");
    op(32'h00000000, 32'hFFFFFFFF, 1'b1, 1'b1, 0, "sub_edge");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_hold_back_to_back();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
